// File: rtl/load_extract_unit_if.sv
// Request/response and memory-read signals of the load extract unit.
// The slave modport is the unit itself; master is the control FSM / memory side.
interface load_extract_unit_if;
  logic        start;
  logic [2:0]  ld_op;
  logic [31:0] addr;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic [31:0] mdr_q;

  modport slave (
    input  start, ld_op, addr, mem_rdata,
    output mem_addr, mem_rd, busy, done, err, load_data, mdr_q
  );

  modport master (
    output start, ld_op, addr, mem_rdata,
    input  mem_addr, mem_rd, busy, done, err, load_data, mdr_q
  );
endinterface

// File: rtl/load_extract_unit.sv
// Fetches one word from data memory with a fixed read latency and returns the
// LW/LH/LHU/LB/LBU register value extracted from the word's low lane.
module load_extract_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  load_extract_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWait, StDone} state_e;

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLhu = 3'b010;
  localparam logic [2:0] OpLb  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;

  // Counter holds the remaining wait cycles after the read strobe.
  localparam logic [3:0] CntInit = 4'(MEM_LATENCY - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] mem_addr_q;
  logic        mem_rd_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] load_data_q;
  logic [31:0] mdr_q_q;

  function automatic logic op_legal(logic [2:0] op);
    return op <= OpLbu;
  endfunction

  function automatic logic [31:0] extract(logic [2:0] op, logic [31:0] w);
    logic [31:0] r;
    r = w;
    unique case (op)
      OpLw:    r = w;
      OpLh:    r = {{16{w[15]}}, w[15:0]};
      OpLhu:   r = {16'b0, w[15:0]};
      OpLb:    r = {{24{w[7]}}, w[7:0]};
      OpLbu:   r = {24'b0, w[7:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
      mdr_q_q     <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted by a transition below.
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q       <= bus.ld_op;
            mem_addr_q <= bus.addr;
            busy_q     <= 1'b1;
            if (op_legal(bus.ld_op)) begin
              mem_rd_q <= 1'b1;
              state_q  <= StRead;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StRead: begin
          cnt_q   <= CntInit;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            mdr_q_q     <= bus.mem_rdata;
            load_data_q <= extract(op_q, bus.mem_rdata);
            done_q      <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.load_data = load_data_q;
  assign bus.mdr_q     = mdr_q_q;

endmodule

// File: tb/tb_load_extract_unit.sv
// Self-checking bench: two units (latency 1 and 3) with a latency-accurate memory model
// and a queue of expected completions.
module tb_load_extract_unit;

  localparam logic [31:0] Garbage = 32'h5A5A_5A5A;

  typedef struct {
    logic [31:0] ld;
    logic [31:0] mdr;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  load_extract_unit_if a ();
  load_extract_unit_if b ();

  load_extract_unit #(.MEM_LATENCY(1)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(a.slave));
  load_extract_unit #(.MEM_LATENCY(3)) u_dut_b (.clk(clk), .reset_n(reset_n), .bus(b.slave));

  int tests = 0;
  int fails = 0;
  exp_t sb_q[$];
  logic [31:0] last_ld [2];
  logic [31:0] last_mdr [2];
  int lat_of [2] = '{3, 5};
  logic [31:0] word_a, word_b;
  int dly_a = 0, dly_b = 0;

  // Memory: data valid only in the cycle MEM_LATENCY cycles after the mem_rd cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      dly_a = 0; a.mem_rdata = Garbage;
    end else if (a.mem_rd) begin
      dly_a = 1; a.mem_rdata = Garbage;
    end else if (dly_a > 0) begin
      dly_a--; a.mem_rdata = (dly_a == 0) ? word_a : Garbage;
    end else a.mem_rdata = Garbage;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      dly_b = 0; b.mem_rdata = Garbage;
    end else if (b.mem_rd) begin
      dly_b = 3; b.mem_rdata = Garbage;
    end else if (dly_b > 0) begin
      dly_b--; b.mem_rdata = (dly_b == 0) ? word_b : Garbage;
    end else b.mem_rdata = Garbage;
  end

  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] w);
    case (op)
      3'd0: return w;
      3'd1: return 32'($signed(w[15:0]));
      3'd2: return 32'(w[15:0]);
      3'd3: return 32'($signed(w[7:0]));
      default: return 32'(w[7:0]);
    endcase
  endfunction

  function automatic logic o_done(int sel);  return sel != 0 ? b.done : a.done; endfunction
  function automatic logic o_err(int sel);   return sel != 0 ? b.err : a.err; endfunction
  function automatic logic o_rd(int sel);    return sel != 0 ? b.mem_rd : a.mem_rd; endfunction
  function automatic logic o_busy(int sel);  return sel != 0 ? b.busy : a.busy; endfunction
  function automatic logic [31:0] o_ld(int sel);  return sel != 0 ? b.load_data : a.load_data; endfunction
  function automatic logic [31:0] o_mdr(int sel); return sel != 0 ? b.mdr_q : a.mdr_q; endfunction
  function automatic logic [31:0] o_ad(int sel);  return sel != 0 ? b.mem_addr : a.mem_addr; endfunction

  task automatic set_in(int sel, logic s, logic [2:0] op, logic [31:0] ad);
    if (sel != 0) begin b.start = s; b.ld_op = op; b.addr = ad; end
    else begin a.start = s; a.ld_op = op; a.addr = ad; end
  endtask

  task automatic drive_start(int sel, logic [2:0] op, logic [31:0] ad, logic [31:0] w);
    exp_t e;
    @(negedge clk);
    set_in(sel, 1'b1, op, ad);
    if (sel != 0) word_b = w; else word_a = w;
    if (op <= 3'd4) begin
      last_ld[sel] = model(op, w); last_mdr[sel] = w; e.err = 1'b0; e.lat = lat_of[sel];
    end else begin
      e.err = 1'b1; e.lat = 1;
    end
    e.ld = last_ld[sel]; e.mdr = last_mdr[sel];
    sb_q.push_back(e);
  endtask

  // Returns at the negedge of the done cycle; lat=0 means the bound expired.
  task automatic wait_done(int sel, bit hold, output int lat, output int rd_n,
                           output logic [31:0] rd_ad);
    lat = 0; rd_n = 0; rd_ad = '0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (hold) set_in(sel, 1'b1, 3'b111, 32'hBAD0_0000 + 32'(c));
      else set_in(sel, 1'b0, 3'b000, 32'h0);
      if (o_rd(sel)) begin rd_n++; rd_ad = o_ad(sel); end
      if (o_done(sel)) lat = c;
    end
  endtask

  task automatic test_reset();
    set_in(0, 1'b0, 3'b000, 32'h0); set_in(1, 1'b0, 3'b000, 32'h0);
    word_a = Garbage; word_b = Garbage;
    last_ld = '{32'h0, 32'h0}; last_mdr = '{32'h0, 32'h0};
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++; if (a.mem_addr !== 32'h0) begin fails++; $display("FAIL reset mem_addr: got %h want 0", a.mem_addr); end
    tests++; if (a.mem_rd !== 1'b0) begin fails++; $display("FAIL reset mem_rd: got %b want 0", a.mem_rd); end
    tests++; if (a.busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", a.busy); end
    tests++; if (a.done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", a.done); end
    tests++; if (a.err !== 1'b0) begin fails++; $display("FAIL reset err: got %b want 0", a.err); end
    tests++; if (a.load_data !== 32'h0) begin fails++; $display("FAIL reset load_data: got %h want 0", a.load_data); end
    tests++; if (a.mdr_q !== 32'h0) begin fails++; $display("FAIL reset mdr_q: got %h want 0", a.mdr_q); end
  endtask

  task automatic test_lw();
    int lat, rd_n; logic [31:0] rd_ad; exp_t e;
    drive_start(0, 3'd0, 32'h40, 32'hDEAD_BEEF);
    wait_done(0, 1'b0, lat, rd_n, rd_ad);
    e = sb_q.pop_front();
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL lw latency: got %0d want %0d", lat, e.lat); end
    tests++; if (rd_n !== 1) begin fails++; $display("FAIL lw mem_rd cycles: got %0d want 1", rd_n); end
    tests++; if (rd_ad !== 32'h40) begin fails++; $display("FAIL lw mem_addr: got %h want 40", rd_ad); end
    tests++; if (a.load_data !== e.ld) begin fails++; $display("FAIL lw load_data: got %h want %h", a.load_data, e.ld); end
    tests++; if (a.mdr_q !== e.mdr) begin fails++; $display("FAIL lw mdr_q: got %h want %h", a.mdr_q, e.mdr); end
    tests++; if (a.err !== e.err) begin fails++; $display("FAIL lw err: got %b want %b", a.err, e.err); end
  endtask

  task automatic test_extract();
    logic [2:0]  ops [6]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
    logic [31:0] words [6] = '{32'h1234_8001, 32'h1234_8001, 32'h0000_00F0,
                               32'h0000_00F0, 32'hAAAA_007F, 32'h8765_43A5};
    int lat, rd_n; logic [31:0] rd_ad; exp_t e;
    for (int i = 0; i < 6; i++) begin
      drive_start(0, ops[i], 32'h100 + 32'(i), words[i]);
      wait_done(0, 1'b0, lat, rd_n, rd_ad);
      e = sb_q.pop_front();
      tests++; if (lat !== e.lat) begin fails++; $display("FAIL extract[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      tests++; if (a.load_data !== e.ld) begin fails++; $display("FAIL extract[%0d] load_data: got %h want %h", i, a.load_data, e.ld); end
      tests++; if (a.mdr_q !== e.mdr) begin fails++; $display("FAIL extract[%0d] mdr_q: got %h want %h", i, a.mdr_q, e.mdr); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, rd_n; logic [31:0] rd_ad; exp_t e;
    drive_start(0, 3'd0, 32'h40, 32'h1122_3344);
    wait_done(0, 1'b1, lat, rd_n, rd_ad);
    e = sb_q.pop_front();
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL b2b first latency: got %0d want %0d", lat, e.lat); end
    tests++; if (rd_ad !== 32'h40) begin fails++; $display("FAIL b2b first mem_addr: got %h want 40", rd_ad); end
    tests++; if (a.load_data !== e.ld) begin fails++; $display("FAIL b2b first load_data: got %h want %h", a.load_data, e.ld); end
    // In the done cycle: switch to a legal op with start still held.
    set_in(0, 1'b1, 3'd4, 32'h80);
    word_a = 32'h0000_00C3; last_ld[0] = model(3'd4, word_a); last_mdr[0] = word_a;
    e.ld = last_ld[0]; e.mdr = last_mdr[0]; e.err = 1'b0; e.lat = 2;
    sb_q.push_back(e);
    @(negedge clk);
    tests++; if (a.busy !== 1'b0) begin fails++; $display("FAIL b2b idle busy: got %b want 0", a.busy); end
    @(negedge clk);
    set_in(0, 1'b0, 3'd0, 32'h0);
    tests++; if (a.mem_rd !== 1'b1) begin fails++; $display("FAIL b2b second mem_rd: got %b want 1", a.mem_rd); end
    tests++; if (a.mem_addr !== 32'h80) begin fails++; $display("FAIL b2b second mem_addr: got %h want 80", a.mem_addr); end
    wait_done(0, 1'b0, lat, rd_n, rd_ad);
    e = sb_q.pop_front();
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL b2b second latency: got %0d want %0d", lat, e.lat); end
    tests++; if (a.load_data !== e.ld) begin fails++; $display("FAIL b2b second load_data: got %h want %h", a.load_data, e.ld); end
  endtask

  task automatic test_illegal();
    int lat, rd_n; logic [31:0] rd_ad; exp_t e;
    drive_start(0, 3'b111, 32'h200, 32'hFFFF_FFFF);
    wait_done(0, 1'b0, lat, rd_n, rd_ad);
    e = sb_q.pop_front();
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL illegal latency: got %0d want %0d", lat, e.lat); end
    tests++; if (rd_n !== 0) begin fails++; $display("FAIL illegal mem_rd cycles: got %0d want 0", rd_n); end
    tests++; if (a.err !== e.err) begin fails++; $display("FAIL illegal err: got %b want %b", a.err, e.err); end
    tests++; if (a.load_data !== e.ld) begin fails++; $display("FAIL illegal load_data: got %h want %h", a.load_data, e.ld); end
    tests++; if (a.mdr_q !== e.mdr) begin fails++; $display("FAIL illegal mdr_q: got %h want %h", a.mdr_q, e.mdr); end
    @(negedge clk);
    tests++; if ({a.done, a.err, a.busy} !== 3'b000) begin fails++; $display("FAIL illegal after done/err/busy: got %b want 000", {a.done, a.err, a.busy}); end
  endtask

  task automatic test_latency3();
    int lat, rd_n; logic [31:0] rd_ad; exp_t e;
    drive_start(1, 3'd0, 32'h300, 32'hCAFE_F00D);
    wait_done(1, 1'b0, lat, rd_n, rd_ad);
    e = sb_q.pop_front();
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL lat3 latency: got %0d want %0d", lat, e.lat); end
    tests++; if (b.load_data !== e.ld) begin fails++; $display("FAIL lat3 load_data: got %h want %h", b.load_data, e.ld); end
    tests++; if (b.mdr_q !== e.mdr) begin fails++; $display("FAIL lat3 mdr_q: got %h want %h", b.mdr_q, e.mdr); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, rd_n; logic [31:0] rd_ad; exp_t e;
    drive_start(1, 3'd2, 32'h304, 32'h0BAD_1234);
    @(negedge clk); set_in(1, 1'b0, 3'd0, 32'h0);
    repeat (2) @(negedge clk);
    tests++; if (o_busy(1) !== 1'b1) begin fails++; $display("FAIL midwait busy: got %b want 1", o_busy(1)); end
    reset_n = 1'b0;
    #1;
    tests++; if ({b.mem_rd, b.busy, b.done, b.err} !== 4'b0) begin fails++; $display("FAIL midwait reset strobes: got %b want 0000", {b.mem_rd, b.busy, b.done, b.err}); end
    tests++; if ({b.mem_addr, b.load_data, b.mdr_q} !== 96'h0) begin fails++; $display("FAIL midwait reset data: got %h want 0", {b.mem_addr, b.load_data, b.mdr_q}); end
    void'(sb_q.pop_front());
    last_ld = '{32'h0, 32'h0}; last_mdr = '{32'h0, 32'h0};
    @(negedge clk);
    reset_n = 1'b1;
    drive_start(1, 3'd1, 32'h308, 32'h7777_9ABC);
    wait_done(1, 1'b0, lat, rd_n, rd_ad);
    e = sb_q.pop_front();
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL postreset latency: got %0d want %0d", lat, e.lat); end
    tests++; if (b.load_data !== e.ld) begin fails++; $display("FAIL postreset load_data: got %h want %h", b.load_data, e.ld); end
    tests++; if (rd_ad !== 32'h308) begin fails++; $display("FAIL postreset mem_addr: got %h want 308", rd_ad); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extract();
    test_back_to_back();
    test_illegal();
    test_latency3();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
